pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised fetch program counter for the RISC-V core; successor to the single-register PC.
- Adds a configurable reset vector, stall, prioritised redirect (trap, then branch/jump), a return-address stack (RAS) for predicted returns, and a misalignment check.
- Sits at the front of IF and drives the instruction memory address and the IF/ID PC.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries (power of 2, ≥2).
- RAS_PTR_W, $clog2(RAS_DEPTH), width of the RAS pointer (derived).

Ports:
- clk  in  1  core clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (hazard unit).
- trap_en  in  1  redirect to trap_vec; highest priority.
- trap_vec  in  XLEN  trap handler address.
- redirect_en  in  1  branch/jump resolved taken in EX.
- redirect_pc  in  XLEN  branch/jump target.
- ras_push  in  1  call decoded; push ras_push_addr.
- ras_push_addr  in  XLEN  link address (call PC+4).
- ras_pop  in  1  return predicted; next PC = RAS top if not empty.
- PC_out  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  PC_out+4, combinational.
- fetch_valid  out  1  PC_out is a valid fetch address.
- misaligned  out  1  one-cycle pulse: rejected redirect target.
- ras_count  out  RAS_PTR_W+1  current RAS occupancy.

Behaviour:
- Reset (sync, while reset=1 at posedge):
  - PC_out=RESET_VECTOR; fetch_valid=0; misaligned=0; RAS cleared with ras_count=0.
  - fetch_valid rises at the first posedge with reset=0.
- Next-PC priority, evaluated each posedge with reset=0:
  1. trap_en: PC_out←{trap_vec[XLEN-1:2],2'b00}. Low bits are forced, so no misaligned pulse. RAS is flushed to count 0.
  2. redirect_en: if redirect_pc[1:0]==0, PC_out←redirect_pc. Otherwise PC_out holds and misaligned=1 for exactly one cycle.
  3. stall: PC_out holds.
  4. ras_pop with count>0: PC_out←top entry, count-1.
  5. Otherwise: PC_out←PC_out+4. Wraps modulo 2^XLEN; all-ones aligned PC+4 → 0.
- trap_en and redirect_en both override stall. ras_pop with count==0 falls through to sequential PC+4 and RAS stays empty.
- misaligned is 0 in every cycle not described in item 2.
- RAS operations are applied only when neither trap_en nor redirect_en is asserted. Redirect leaves RAS contents unchanged.
- RAS operations while stall=1 are ignored. The upstream stage holds its request.
- RAS push:
  - Write at top+1; count saturates at RAS_DEPTH.
  - On overflow the oldest entry is overwritten (circular buffer); count stays RAS_DEPTH.
- Simultaneous ras_push and ras_pop, not stalled, count>0:
  - PC_out←old top.
  - Top entry is replaced by ras_push_addr; count unchanged.
- Simultaneous ras_push and ras_pop with count==0: sequential PC, push performed, count=1.
- Latency: every redirect or pop takes effect on PC_out at the next posedge (1 cycle); no bubbles are inserted internally.
- Reset asserted mid-operation wins over all other inputs in the same cycle.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEFAULT and RESET_VECTOR_DEFAULT.
  - The PC increment constant (4).
  - The next-PC select enum: NPC_TRAP, NPC_REDIRECT, NPC_HOLD, NPC_RAS, NPC_SEQ.
- One sub-module, ras_stack, is natural: a circular buffer with push/pop/flush, top and count outputs, parametrised on XLEN and RAS_DEPTH.
- The pc_unit top holds the priority mux, PC register, fetch_valid and misaligned logic.

Test Plan:
- Reset/sequential: reset=1 for 2 cycles with RESET_VECTOR=32'h0000_1000, then release. Expect PC_out 0x1000, 0x1004, 0x1008; fetch_valid 0 during reset, 1 after.
- Stall vs redirect: stall=1 for 3 cycles holds PC_out at 0x1008. stall=1 with redirect_en, redirect_pc=0x2000 gives PC_out=0x2000 next cycle.
- Trap priority: trap_en with trap_vec=0x303, together with redirect_en to 0x4000. Expect PC_out=0x300, ras_count=0, misaligned=0.
- Misaligned: redirect_pc=0x2002. Expect PC_out unchanged, misaligned=1 for one cycle only.
- RAS with DEPTH=4:
  - Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0; ras_count saturates at 4.
  - Pops return 0xE0, 0xD0, 0xC0, 0xB0; 0xA0 was lost to overflow.
  - A fifth pop gives sequential PC+4.
- Simultaneous push+pop, stack {0x50,0x60}, push 0x70: PC_out=0x60; ras_count stays 2; next pop yields 0x70. Wrap check: PC_out=0xFFFF_FFFC sequential gives 0x0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, PC increment and next-PC select encoding.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Fixed instruction size; no compressed instructions.
    localparam int unsigned PC_INCR = 4;

    // Next-PC source, listed in decreasing priority.
    typedef enum logic [2:0] {
        NPC_TRAP,
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_RAS,
        NPC_SEQ
    } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer that overwrites the oldest entry when full.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [XLEN-1:0]      push_addr,
    output logic [XLEN-1:0]      top,
    output logic [RAS_PTR_W:0]   count
);

    localparam int unsigned CNT_W = RAS_PTR_W + 1;
    localparam logic [RAS_PTR_W:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]      mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ptr_q, ptr_d;
    logic [RAS_PTR_W:0]   count_q, count_d;
    logic                 wr_en;
    logic [RAS_PTR_W-1:0] wr_idx;
    logic                 not_empty;

    assign not_empty = (count_q != '0);

    // Pointer/count update and write port selection.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (flush) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push && pop && not_empty) begin
            // Caller consumes the old top; the new link replaces it in place.
            wr_en = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (count_q != CNT_FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && not_empty) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_addr;
        end
    end

    assign top   = mem[ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, trap/branch redirect, return-address stack and
// misaligned-target rejection.
module pc_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter int unsigned     RAS_PTR_W    = $clog2(RAS_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 trap_en,
    input  logic [XLEN-1:0]      trap_vec,
    input  logic                 redirect_en,
    input  logic [XLEN-1:0]      redirect_pc,
    input  logic                 ras_push,
    input  logic [XLEN-1:0]      ras_push_addr,
    input  logic                 ras_pop,
    output logic [XLEN-1:0]      PC_out,
    output logic [XLEN-1:0]      pc_plus4,
    output logic                 fetch_valid,
    output logic                 misaligned,
    output logic [RAS_PTR_W:0]   ras_count
);

    npc_sel_e             npc_sel;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic                 fetch_valid_q;
    logic                 misaligned_q, misaligned_d;
    logic                 ras_ok;
    logic [XLEN-1:0]      ras_top;
    logic [RAS_PTR_W:0]   ras_cnt;

    // Stack traffic is only honoured on a plain, unstalled fetch cycle.
    assign ras_ok = !trap_en && !redirect_en && !stall;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .RAS_PTR_W (RAS_PTR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .flush     (trap_en),
        .push      (ras_push && ras_ok),
        .pop       (ras_pop && ras_ok),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .count     (ras_cnt)
    );

    assign pc_plus4 = pc_q + XLEN'(PC_INCR);

    // Prioritised next-PC source selection.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (trap_en) begin
            npc_sel = NPC_TRAP;
        end else if (redirect_en) begin
            npc_sel = NPC_REDIRECT;
        end else if (stall) begin
            npc_sel = NPC_HOLD;
        end else if (ras_pop && (ras_cnt != '0)) begin
            npc_sel = NPC_RAS;
        end
    end

    // Next-PC mux and misaligned-target detection.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        case (npc_sel)
            NPC_TRAP:     pc_d = {trap_vec[XLEN-1:2], 2'b00};
            NPC_REDIRECT: begin
                if (redirect_pc[1:0] == 2'b00) begin
                    pc_d = redirect_pc;
                end else begin
                    misaligned_d = 1'b1;
                end
            end
            NPC_HOLD:     pc_d = pc_q;
            NPC_RAS:      pc_d = ras_top;
            NPC_SEQ:      pc_d = pc_plus4;
            default:      pc_d = pc_q;
        endcase
    end

    // PC, fetch-valid and misaligned-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
            misaligned_q  <= misaligned_d;
        end
    end

    assign PC_out      = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign misaligned  = misaligned_q;
    assign ras_count   = ras_cnt;

endmodule
